core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle control FSM for the core. Fetches 32-bit instructions over a req/ack port and holds
//  each in o_insn for the combinational decoder. Acts on the decoder's valid/to_state verdict.
//  Drives the ALU start/done handshake and the GPR write-back port, and owns PC, halt and fault.
// PARAMETERS
//  RESET_PC     64'h0  PC value loaded on reset.
//  ALU_TIMEOUT  16     max cycles in EXEC waiting for i_alu_done before faulting (>=1).
//  CNT_W        32     width of retired-instruction counter.
// PORTS
//  i_clk          in   1      clock; all state changes on rising edge.
//  i_rst_n        in   1      reset, synchronous, active-low.
//  o_imem_req     out  1      fetch request; held high until ack.
//  o_imem_addr    out  64     fetch address (= o_pc), stable while req high.
//  i_imem_ack     in   1      fetch complete; i_imem_data valid this cycle.
//  i_imem_data    in   32     fetched instruction word.
//  o_insn         out  32     latched instruction, drives decoder i_insn.
//  i_dec_valid    in   1      decoder: instruction legal.
//  i_dec_to_state in   4      decoder: STATE_* code (cpustate.vinc).
//  i_dec_dst      in   5      decoder: destination GPR index.
//  i_dec_src1     in   64     decoder: operand 1 (immediate result for SRC1_TO_DST).
//  o_alu_start    out  1      one-cycle pulse launching the ALU on decoder operands.
//  i_alu_done     in   1      ALU result valid.
//  i_alu_result   in   64     ALU result.
//  o_wb_en        out  1      one-cycle GPR write strobe.
//  o_wb_addr      out  5      GPR write index.
//  o_wb_data      out  64     GPR write data.
//  o_pc           out  64     current program counter.
//  o_halted       out  1      sticky: HALT executed.
//  o_fault        out  1      sticky: illegal insn or ALU timeout.
//  o_retired      out  CNT_W  retired-instruction count.
// BEHAVIOUR
//  States: FETCH, DECODE, EXEC, WB, STOP. Reset (i_rst_n=0 at edge) -> FETCH, o_pc=RESET_PC,
//   o_insn=0, all strobes/flags 0, o_retired=0, timeout cnt=0. Reset wins over every event,
//   including an ack or done arriving in the same cycle.
//  FETCH: o_imem_req=1, o_imem_addr=o_pc. On i_imem_ack: o_insn<=i_imem_data, req drops the
//   next cycle, -> DECODE. No ack -> wait indefinitely.
//  DECODE (1 cycle; decoder outputs sampled this cycle):
//   !i_dec_valid -> o_fault<=1, STOP. to_state==HALT -> o_halted<=1, o_retired+1, STOP.
//   SRC1_TO_DST -> wb_data<=i_dec_src1, wb_addr<=i_dec_dst, -> WB.
//   EXECUTE -> o_alu_start=1 for the next cycle only, cnt<=0, -> EXEC.
//   Any other to_state code -> treated as illegal (fault).
//  EXEC: o_insn held constant. On i_alu_done: wb_data<=i_alu_result, wb_addr<=i_dec_dst, -> WB.
//   If ALU_TIMEOUT cycles elapse without done -> o_fault<=1, STOP. A done arriving in the
//   timeout cycle counts as success.
//  WB (1 cycle): o_wb_en=1; o_pc<=o_pc+4 (64-bit wrap, 64'hFFFF_FFFF_FFFF_FFFC -> 0);
//   o_retired+1 (wraps at 2^CNT_W); -> FETCH.
//  STOP: terminal; all strobes 0, o_pc frozen, flags held; leave only via reset.
//  Latency: legal immediate insn = ack + 2 cycles to wb_en; ALU insn = done + 1 cycle to wb_en.
//  o_alu_start and o_wb_en are never high in the same cycle; neither is high while req=1.
// TESTING
//  1. Reset, RESET_PC=0x100, ack after 3 cycles with a load-immediate of 0x1234 to r5
//     -> req held 3 cycles at addr 0x100; wb_en pulse one cycle later, wb_addr=5,
//     wb_data=0x1234; pc=0x104; retired=1.
//  2. ALU insn, done 5 cycles after start -> one start pulse; wb_data=i_alu_result;
//     wb_en exactly 1 cycle after done.
//  3. Insn word 0x0000_0000 (HALT) -> o_halted=1, retired+1, no wb_en; req never reasserts
//     across 50 cycles.
//  4. Illegal insn (dec_valid=0), then ALU_TIMEOUT=4 with done held low -> o_fault=1 in both
//     cases, no wb_en; done exactly on the 4th cycle -> success, no fault.
//  5. i_rst_n low in the same cycle as ack, and again during EXEC -> FETCH at RESET_PC,
//     flags/counter cleared, no stray start or wb_en.
//  6. pc=64'hFFFF_FFFF_FFFF_FFFC, retired=2^CNT_W-1, legal insn -> pc=0 and retired=0 after WB.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: fetches an instruction, acts on the decoder verdict, runs the ALU
// handshake and GPR write-back, and owns PC, halt/fault flags and the retired-instruction count.
module core_sequencer #(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int unsigned ALU_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   output logic             o_imem_req,
   output logic [63:0]      o_imem_addr,
   input  logic             i_imem_ack,
   input  logic [31:0]      i_imem_data,
   output logic [31:0]      o_insn,
   input  logic             i_dec_valid,
   input  logic [3:0]       i_dec_to_state,
   input  logic [4:0]       i_dec_dst,
   input  logic [63:0]      i_dec_src1,
   output logic             o_alu_start,
   input  logic             i_alu_done,
   input  logic [63:0]      i_alu_result,
   output logic             o_wb_en,
   output logic [4:0]       o_wb_addr,
   output logic [63:0]      o_wb_data,
   output logic [63:0]      o_pc,
   output logic             o_halted,
   output logic             o_fault,
   output logic [CNT_W-1:0] o_retired
);

   // Decoder next-state codes shared with the decoder.
   localparam logic [3:0] STATE_HALT        = 4'h0;
   localparam logic [3:0] STATE_SRC1_TO_DST = 4'h1;
   localparam logic [3:0] STATE_EXECUTE     = 4'h2;

   localparam int unsigned TMO_W = $clog2(ALU_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ALU_TIMEOUT - 1);

   typedef enum logic [2:0] {StFetch, StDecode, StExec, StWb, StStop} state_e;

   state_e             state_q, state_d;
   logic [63:0]        pc_q, pc_d;
   logic [31:0]        insn_q, insn_d;
   logic [4:0]         wb_addr_q, wb_addr_d;
   logic [63:0]        wb_data_q, wb_data_d;
   logic               halted_q, halted_d;
   logic               fault_q, fault_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic [TMO_W-1:0]   cnt_q, cnt_d;
   logic               start_q, start_d;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      insn_d    = insn_q;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      halted_d  = halted_q;
      fault_d   = fault_q;
      retired_d = retired_q;
      cnt_d     = cnt_q;
      start_d   = 1'b0;
      unique case (state_q)
         StFetch: begin
            if (i_imem_ack) begin
               insn_d  = i_imem_data;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (!i_dec_valid) begin
               fault_d = 1'b1;
               state_d = StStop;
            end else begin
               case (i_dec_to_state)
                  STATE_HALT: begin
                     halted_d  = 1'b1;
                     retired_d = retired_q + CNT_W'(1);
                     state_d   = StStop;
                  end
                  STATE_SRC1_TO_DST: begin
                     wb_data_d = i_dec_src1;
                     wb_addr_d = i_dec_dst;
                     state_d   = StWb;
                  end
                  STATE_EXECUTE: begin
                     start_d = 1'b1;
                     cnt_d   = '0;
                     state_d = StExec;
                  end
                  default: begin
                     fault_d = 1'b1;
                     state_d = StStop;
                  end
               endcase
            end
         end
         StExec: begin
            // A done in the final allowed cycle still wins over the timeout.
            if (i_alu_done) begin
               wb_data_d = i_alu_result;
               wb_addr_d = i_dec_dst;
               state_d   = StWb;
            end else if (cnt_q == TMO_LAST) begin
               fault_d = 1'b1;
               state_d = StStop;
            end else begin
               cnt_d = cnt_q + TMO_W'(1);
            end
         end
         StWb: begin
            pc_d      = pc_q + 64'd4;
            retired_d = retired_q + CNT_W'(1);
            state_d   = StFetch;
         end
         StStop: begin
            state_d = StStop;
         end
         default: begin
            state_d = StFetch;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= StFetch;
         pc_q      <= RESET_PC;
         insn_q    <= '0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         halted_q  <= 1'b0;
         fault_q   <= 1'b0;
         retired_q <= '0;
         cnt_q     <= '0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         insn_q    <= insn_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         halted_q  <= halted_d;
         fault_q   <= fault_d;
         retired_q <= retired_d;
         cnt_q     <= cnt_d;
         start_q   <= start_d;
      end
   end

   assign o_imem_req  = (state_q == StFetch);
   assign o_imem_addr = pc_q;
   assign o_insn      = insn_q;
   assign o_alu_start = start_q;
   assign o_wb_en     = (state_q == StWb);
   assign o_wb_addr   = wb_addr_q;
   assign o_wb_data   = wb_data_q;
   assign o_pc        = pc_q;
   assign o_halted    = halted_q;
   assign o_fault     = fault_q;
   assign o_retired   = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: instance A covers the main flows, instance B (short
// timeout, narrow counter, PC near the top) covers the timeout and wrap boundaries.
module tb_core_sequencer;

   logic        clk = 1'b0;
   logic        rst_a_n = 1'b0, rst_b_n = 1'b0;
   logic        sel = 1'b0;
   logic        ack = 1'b0, done = 1'b0;
   logic [31:0] data = '0;
   logic [63:0] result = '0;
   logic        dec_valid;
   logic [3:0]  dec_to;
   logic [4:0]  dec_dst;
   logic [63:0] dec_src1;

   logic        a_req, a_start, a_wb, a_halt, a_fault;
   logic [63:0] a_addr, a_wdata, a_pc;
   logic [31:0] a_insn, a_ret;
   logic [4:0]  a_waddr;
   logic        b_req, b_start, b_wb, b_halt, b_fault;
   logic [63:0] b_addr, b_wdata, b_pc;
   logic [31:0] b_insn;
   logic [1:0]  b_ret;
   logic [4:0]  b_waddr;

   logic        req, start, wb_en, halted, fault;
   logic [63:0] addr, wb_data, pc;
   logic [31:0] insn, retired;
   logic [4:0]  wb_addr;

   int tests = 0, failed = 0, viol = 0;

   always #5 clk = ~clk;

   core_sequencer #(.RESET_PC(64'h100), .ALU_TIMEOUT(16), .CNT_W(32)) dut_a (
      .i_clk(clk), .i_rst_n(rst_a_n), .o_imem_req(a_req), .o_imem_addr(a_addr),
      .i_imem_ack(ack), .i_imem_data(data), .o_insn(a_insn), .i_dec_valid(dec_valid),
      .i_dec_to_state(dec_to), .i_dec_dst(dec_dst), .i_dec_src1(dec_src1),
      .o_alu_start(a_start), .i_alu_done(done), .i_alu_result(result), .o_wb_en(a_wb),
      .o_wb_addr(a_waddr), .o_wb_data(a_wdata), .o_pc(a_pc), .o_halted(a_halt),
      .o_fault(a_fault), .o_retired(a_ret));

   core_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF0), .ALU_TIMEOUT(4), .CNT_W(2)) dut_b (
      .i_clk(clk), .i_rst_n(rst_b_n), .o_imem_req(b_req), .o_imem_addr(b_addr),
      .i_imem_ack(ack), .i_imem_data(data), .o_insn(b_insn), .i_dec_valid(dec_valid),
      .i_dec_to_state(dec_to), .i_dec_dst(dec_dst), .i_dec_src1(dec_src1),
      .o_alu_start(b_start), .i_alu_done(done), .i_alu_result(result), .o_wb_en(b_wb),
      .o_wb_addr(b_waddr), .o_wb_data(b_wdata), .o_pc(b_pc), .o_halted(b_halt),
      .o_fault(b_fault), .o_retired(b_ret));

   // The idle instance is held in reset, so shared inputs only affect the selected one.
   assign req     = sel ? b_req   : a_req;
   assign addr    = sel ? b_addr  : a_addr;
   assign insn    = sel ? b_insn  : a_insn;
   assign start   = sel ? b_start : a_start;
   assign wb_en   = sel ? b_wb    : a_wb;
   assign wb_addr = sel ? b_waddr : a_waddr;
   assign wb_data = sel ? b_wdata : a_wdata;
   assign pc      = sel ? b_pc    : a_pc;
   assign halted  = sel ? b_halt  : a_halt;
   assign fault   = sel ? b_fault : a_fault;
   assign retired = sel ? {30'b0, b_ret} : a_ret;

   // Decoder model: [31:28] opcode, [20:16] dst, [15:0] immediate.
   always_comb begin
      dec_valid = 1'b1;
      dec_to    = 4'h7;
      dec_dst   = insn[20:16];
      dec_src1  = {48'h0, insn[15:0]};
      case (insn[31:28])
         4'h0:    if (insn == 32'h0) dec_to = 4'h0; else dec_valid = 1'b0;
         4'h1:    dec_to = 4'h1;
         4'h2:    dec_to = 4'h2;
         4'h3:    dec_to = 4'h7;
         default: dec_valid = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (start && wb_en) viol++;
      if ((start || wb_en) && req) viol++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic s);
      sel = s; ack = 1'b0; done = 1'b0;
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      cyc(); cyc();
      if (s) rst_b_n = 1'b1; else rst_a_n = 1'b1;
   endtask

   task automatic fetch(input logic [31:0] word, input int ack_dly, input logic [63:0] exp_pc,
                        output int bad);
      bad = 0;
      for (int i = 0; i < ack_dly; i++) begin
         if (!req || addr !== exp_pc) bad++;
         cyc();
      end
      ack = 1'b1; data = word;
      if (!req || addr !== exp_pc) bad++;
      cyc();
      ack = 1'b0;
      if (req) bad++;
   endtask

   // t=0 is the decode cycle; records first wb_en / fault cycle and strobe counts.
   task automatic run_insn(input logic [31:0] word, input int ack_dly, input int alu_dly,
                           input logic [63:0] res, input logic [63:0] exp_pc,
                           output int bad, output int wb_t, output int nwb,
                           output int nstart, output int fault_t);
      int start_t;
      fetch(word, ack_dly, exp_pc, bad);
      result = res;
      wb_t = -1; nwb = 0; nstart = 0; fault_t = -1; start_t = -1;
      for (int t = 0; t < 30; t++) begin
         if (wb_en) begin nwb++; if (wb_t < 0) wb_t = t; end
         if (start) begin nstart++; if (start_t < 0) start_t = t; end
         if (fault && fault_t < 0) fault_t = t;
         done = (start_t >= 0 && alu_dly >= 0 && t == start_t + alu_dly);
         cyc();
      end
      done = 1'b0;
   endtask

   typedef struct {
      logic [31:0] word;
      int          ack_dly;
      int          alu_dly;
      logic [63:0] res;
      int          wb_t;
      int          nstart;
      logic [4:0]  waddr;
      logic [63:0] wdata;
      logic        fault;
      logic        halt;
      logic [63:0] pc;
      logic [31:0] ret;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int bad, wb_t, nwb, nstart, fault_t, cnt;
      vecs[0] = '{32'h1005_1234, 3, -1, 64'h0, 1, 0, 5'd5, 64'h1234, 1'b0, 1'b0, 64'h104, 32'd1};
      vecs[1] = '{32'h2007_0000, 1, 5, 64'hDEAD_BEEF_0000_0001, 7, 1, 5'd7,
                  64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 64'h104, 32'd1};
      vecs[2] = '{32'h0000_0000, 0, -1, 64'h0, -1, 0, 5'd0, 64'h0, 1'b0, 1'b1, 64'h100, 32'd1};
      vecs[3] = '{32'hF000_0000, 2, -1, 64'h0, -1, 0, 5'd0, 64'h0, 1'b1, 1'b0, 64'h100, 32'd0};
      vecs[4] = '{32'h3000_0000, 0, -1, 64'h0, -1, 0, 5'd0, 64'h0, 1'b1, 1'b0, 64'h100, 32'd0};
      vecs[5] = '{32'h2003_0000, 0, -1, 64'h55, -1, 1, 5'd0, 64'h0, 1'b1, 1'b0, 64'h100, 32'd0};
      vecs[6] = '{32'h201F_0000, 0, 0, 64'h5, 2, 1, 5'd31, 64'h5, 1'b0, 1'b0, 64'h104, 32'd1};
      vecs[7] = '{32'h2001_0000, 1, 15, 64'hFFFF_FFFF_FFFF_FFFF, 17, 1, 5'd1,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h104, 32'd1};

      do_reset(1'b0);
      check("rst_req", req, 1);
      check("rst_pc", pc, 64'h100);
      check("rst_insn", insn, 0);
      check("rst_flags", {halted, fault, start, wb_en}, 0);
      check("rst_retired", retired, 0);

      for (int v = 0; v < 8; v++) begin
         do_reset(1'b0);
         run_insn(vecs[v].word, vecs[v].ack_dly, vecs[v].alu_dly, vecs[v].res, 64'h100,
                  bad, wb_t, nwb, nstart, fault_t);
         check($sformatf("v%0d_req_hold", v), bad, 0);
         check($sformatf("v%0d_wb_t", v), wb_t, vecs[v].wb_t);
         check($sformatf("v%0d_nwb", v), nwb, (vecs[v].wb_t >= 0) ? 1 : 0);
         check($sformatf("v%0d_nstart", v), nstart, vecs[v].nstart);
         check($sformatf("v%0d_wb_addr", v), wb_addr, vecs[v].waddr);
         check($sformatf("v%0d_wb_data", v), wb_data, vecs[v].wdata);
         check($sformatf("v%0d_fault", v), fault, vecs[v].fault);
         check($sformatf("v%0d_halted", v), halted, vecs[v].halt);
         check($sformatf("v%0d_pc", v), pc, vecs[v].pc);
         check($sformatf("v%0d_retired", v), retired, vecs[v].ret);
      end

      // Halt after one retired insn: req must stay low for 50 cycles.
      do_reset(1'b0);
      run_insn(32'h1003_00AA, 0, -1, 64'h0, 64'h100, bad, wb_t, nwb, nstart, fault_t);
      run_insn(32'h0000_0000, 0, -1, 64'h0, 64'h104, bad, wb_t, nwb, nstart, fault_t);
      check("halt_nwb", nwb, 0);
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         if (req || wb_en || start) cnt++;
         cyc();
      end
      check("halt_quiet", cnt, 0);
      check("halt_flag", halted, 1);
      check("halt_retired", retired, 2);
      check("halt_pc", pc, 64'h104);

      // Reset coinciding with an ack.
      do_reset(1'b0);
      run_insn(32'h1005_1234, 0, -1, 64'h0, 64'h100, bad, wb_t, nwb, nstart, fault_t);
      ack = 1'b1; data = 32'h1006_5555; rst_a_n = 1'b0;
      cyc();
      ack = 1'b0; rst_a_n = 1'b1;
      check("rack_req", req, 1);
      check("rack_pc", pc, 64'h100);
      check("rack_insn", insn, 0);
      check("rack_state", {retired, 27'b0, wb_addr}, 0);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (wb_en || start || !req) cnt++;
         cyc();
      end
      check("rack_quiet", cnt, 0);

      // Reset during EXEC with a done arriving in the same cycle.
      do_reset(1'b0);
      run_insn(32'h1005_1234, 0, -1, 64'h0, 64'h100, bad, wb_t, nwb, nstart, fault_t);
      fetch(32'h2004_0000, 0, 64'h104, bad);
      cyc(); cyc(); cyc();
      done = 1'b1; result = 64'h77; rst_a_n = 1'b0;
      cyc();
      done = 1'b0; rst_a_n = 1'b1;
      check("rexec_pc", pc, 64'h100);
      check("rexec_flags", {halted, fault, start, wb_en}, 0);
      check("rexec_retired", retired, 0);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (wb_en || start || !req) cnt++;
         cyc();
      end
      check("rexec_quiet", cnt, 0);

      // Instance B: done on the last allowed cycle, PC/counter wrap, then timeout.
      do_reset(1'b1);
      run_insn(32'h1002_0001, 0, -1, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, bad, wb_t, nwb, nstart,
               fault_t);
      run_insn(32'h2002_0000, 0, 3, 64'hABC, 64'hFFFF_FFFF_FFFF_FFF4, bad, wb_t, nwb, nstart,
               fault_t);
      check("b_edge_wb_t", wb_t, 5);
      check("b_edge_fault", fault_t, -1);
      check("b_edge_wb_data", wb_data, 64'hABC);
      run_insn(32'h1002_0002, 0, -1, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, bad, wb_t, nwb, nstart,
               fault_t);
      check("b_pre_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
      check("b_pre_retired", retired, 3);
      run_insn(32'h1002_0003, 0, -1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, bad, wb_t, nwb, nstart,
               fault_t);
      check("b_wrap_req_addr", bad, 0);
      check("b_wrap_pc", pc, 64'h0);
      check("b_wrap_retired", retired, 0);
      run_insn(32'h2002_0000, 0, -1, 64'h0, 64'h0, bad, wb_t, nwb, nstart, fault_t);
      check("b_tmo_fault_t", fault_t, 5);
      check("b_tmo_nwb", nwb, 0);
      check("b_tmo_pc", pc, 64'h0);
      do_reset(1'b1);
      check("b_rst_fault", fault, 0);
      run_insn(32'hF123_0000, 1, -1, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, bad, wb_t, nwb, nstart,
               fault_t);
      check("b_illegal_fault", fault, 1);
      check("b_illegal_nwb", nwb, 0);

      check("strobe_invariants", viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
